// File: rtl/ledg_sequencer.sv
// rtl/ledg_sequencer.sv - autonomous LED pattern sequencer: Avalon-MM slave registers, Avalon-MM master writes to LEDG PIO
module ledg_sequencer #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH4 = 4'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]       state;
    logic             run;
    logic             loop_en;
    logic             done;
    logic [31:0]      period;
    logic [3:0]       length;
    logic [3:0]       index;
    logic [31:0]      cnt;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] pattern [DEPTH];

    logic        wr;
    logic        ctrl_wr;
    logic [3:0]  slot;
    logic        pat_sel;
    logic        start;
    logic [31:0] period_eff;
    logic [3:0]  len_eff;

    assign wr      = s_chipselect && !s_write_n;
    assign ctrl_wr = wr && (s_address == 4'd0);
    assign slot    = s_address - 4'd8;
    assign pat_sel = s_address[3] && (slot < DEPTH4);
    // A start is a 0->1 edge of run taken from IDLE; writing run=1 while busy only updates loop.
    assign start   = ctrl_wr && s_writedata[0] && !run && (state == S_IDLE);

    always_comb begin
        period_eff = (period == 32'd0) ? 32'd1 : period;
        if (length == 4'd0)
            len_eff = 4'd1;
        else if (length > DEPTH4)
            len_eff = DEPTH4;
        else
            len_eff = length;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            run     <= 1'b0;
            loop_en <= 1'b0;
            done    <= 1'b0;
            period  <= '0;
            length  <= '0;
            index   <= '0;
            cnt     <= '0;
            data    <= '0;
            for (int i = 0; i < DEPTH; i++)
                pattern[i] <= '0;
        end else begin
            if (wr && pat_sel)
                pattern[slot[IW-1:0]] <= s_writedata[WIDTH-1:0];
            if (wr && (s_address == 4'd1))
                period <= s_writedata;
            if (wr && (s_address == 4'd2))
                length <= s_writedata[3:0];
            if (ctrl_wr) begin
                run     <= s_writedata[0];
                loop_en <= s_writedata[1];
                if (s_writedata[2])
                    done <= 1'b0;
            end

            // FSM assignments come last so a hardware done-set overrides a same-cycle clear.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_WRITE;
                        index <= '0;
                        done  <= 1'b0;
                        data  <= pattern[0];
                    end
                end
                S_WRITE: begin
                    if (!m_waitrequest) begin
                        cnt   <= period_eff - 32'd1;
                        state <= run ? S_WAIT : S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (!run) begin
                        state <= S_IDLE;
                    end else if (cnt != 32'd0) begin
                        cnt <= cnt - 32'd1;
                    end else if (index < len_eff - 4'd1) begin
                        index <= index + 4'd1;
                        data  <= pattern[IW'(index + 4'd1)];
                        state <= S_WRITE;
                    end else if (loop_en) begin
                        index <= '0;
                        data  <= pattern[0];
                        state <= S_WRITE;
                    end else begin
                        done  <= 1'b1;
                        run   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        s_readdata = '0;
        case (s_address)
            4'd0: s_readdata = {28'd0, done, 1'b0, loop_en, run};
            4'd1: s_readdata = period;
            4'd2: s_readdata = {28'd0, length};
            4'd3: s_readdata = {27'd0, (state != S_IDLE), index};
            default: begin
                if (pat_sel)
                    s_readdata[WIDTH-1:0] = pattern[slot[IW-1:0]];
            end
        endcase
    end

    always_comb begin
        m_address    = 2'd0;
        m_chipselect = (state == S_WRITE);
        m_write_n    = (state != S_WRITE);
        m_writedata  = '0;
        if (state == S_WRITE)
            m_writedata[WIDTH-1:0] = data;
    end
endmodule

// File: tb/tb_ledg_sequencer.sv
// tb/tb_ledg_sequencer.sv - scoreboard bench for ledg_sequencer with a sequence-level reference model
module tb_ledg_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  s_address = '0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n = 1'b1;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;

    ledg_sequencer #(.WIDTH(9), .DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
        .s_writedata(s_writedata), .s_readdata(s_readdata),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .m_waitrequest(m_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          gap;
    } exp_t;

    exp_t        expq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          prev_acc = 0;
    int          last_wr_cyc = 0;
    logic [8:0]  pat_m [8];
    logic [31:0] rv;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected write on every accepted master write.
    initial begin
        logic        stall_prev;
        logic [31:0] stall_data;
        exp_t        e;
        stall_prev = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_prev = 1'b0;
            end else if (m_chipselect && !m_write_n) begin
                if (stall_prev) begin
                    chk("stall_data", m_writedata, stall_data);
                    chk("stall_addr", 32'(m_address), 32'd0);
                end
                if (m_waitrequest) begin
                    stall_prev = 1'b1;
                    stall_data = m_writedata;
                end else begin
                    stall_prev = 1'b0;
                    chk("m_address", 32'(m_address), 32'd0);
                    if (expq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: got %h want none", m_writedata);
                    end else begin
                        e = expq.pop_front();
                        chk("wr_data", m_writedata, e.data);
                        if (e.gap > 0)
                            chk("wr_gap", 32'(cyc - prev_acc), 32'(e.gap));
                    end
                    prev_acc = cyc;
                    acc_cnt++;
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic sw(input logic [3:0] a, input logic [31:0] d);
        s_address    = a;
        s_writedata  = d;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        last_wr_cyc  = cyc;
        @(posedge clk);
        #1;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        s_address = a;
        #1;
        d = s_readdata;
        @(posedge clk);
        #1;
    endtask

    task automatic set_pat(input int i, input logic [31:0] v);
        sw(4'(8 + i), v);
        pat_m[i] = v[8:0];
    endtask

    function automatic int len_eff(input int len);
        if (len == 0) return 1;
        if (len > 8) return 8;
        return len;
    endfunction

    function automatic int per_eff(input int per);
        return (per == 0) ? 1 : per;
    endfunction

    // Reference: a sequence of n writes cycling over the first len_eff patterns.
    task automatic push_seq(input int len, input int per, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = 32'(pat_m[i % len_eff(len)]);
            e.gap  = (i == 0) ? 1 : per_eff(per) + 1;
            expq.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (expq.size() > 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (expq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending want 0", name, expq.size());
            expq.delete();
        end
    endtask

    task automatic wait_acc(input string name, input int target);
        int n = 0;
        while (acc_cnt < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (acc_cnt < target) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d want %0d", name, acc_cnt, target);
        end
    endtask

    task automatic idle_gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_oneshot(input int len, input int per);
        sw(4'd1, 32'(per));
        sw(4'd2, 32'(len));
        push_seq(len, per, len_eff(len));
        sw(4'd0, 32'h1);
        prev_acc = last_wr_cyc;
        rd(4'd0, rv);
        chk("ctrl_started", rv, 32'h1);
        wait_drain("oneshot");
        idle_gap(per_eff(per) + 4);
        rd(4'd0, rv);
        chk("ctrl_done", rv, 32'h8);
        rd(4'd3, rv);
        chk("status_end", rv, 32'(len_eff(len) - 1));
        sw(4'd0, 32'h4);
        rd(4'd0, rv);
        chk("ctrl_cleared", rv, 32'h0);
    endtask

    task automatic run_loop(input int len, input int per, input int k);
        int base;
        sw(4'd1, 32'(per));
        sw(4'd2, 32'(len));
        push_seq(len, per, k);
        base = acc_cnt;
        sw(4'd0, 32'h3);
        prev_acc = last_wr_cyc;
        wait_acc("loop", base + k);
        #1;
        sw(4'd0, 32'h0);
        idle_gap(per_eff(per) + 6);
        chk("loop_count", 32'(acc_cnt - base), 32'(k));
        rd(4'd3, rv);
        chk("loop_status", rv, 32'((k - 1) % len_eff(len)));
        expq.delete();
    endtask

    initial begin
        int n;
        int base;
        exp_t e;
        for (int i = 0; i < 8; i++) pat_m[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a stalled write.
        set_pat(0, 32'h0AB);
        set_pat(5, 32'h155);
        sw(4'd1, 32'd7);
        m_waitrequest = 1'b1;
        sw(4'd0, 32'h3);
        chk("cs_before_reset", 32'(m_chipselect), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("cs_async_reset", 32'(m_chipselect), 32'd0);
        chk("wn_async_reset", 32'(m_write_n), 32'd1);
        chk("wd_async_reset", m_writedata, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_waitrequest = 1'b0;
        for (int i = 0; i < 8; i++) pat_m[i] = '0;
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), rv);
            chk($sformatf("reset_reg%0d", a), rv, 32'd0);
        end

        // One-shot with fixed patterns.
        set_pat(0, 32'h001);
        set_pat(1, 32'h002);
        set_pat(2, 32'h004);
        run_oneshot(3, 4);

        // Loop then stop during WAIT.
        set_pat(0, 32'h1FF);
        set_pat(1, 32'h000);
        run_loop(2, 2, 4);

        // Backpressure: 3-cycle stall on the second write.
        set_pat(0, 32'h011);
        set_pat(1, 32'h022);
        set_pat(2, 32'h044);
        sw(4'd1, 32'd3);
        sw(4'd2, 32'd3);
        push_seq(3, 3, 3);
        expq[1].gap = 3 + 1 + 3;
        base = acc_cnt;
        sw(4'd0, 32'h1);
        prev_acc = last_wr_cyc;
        wait_acc("bp", base + 1);
        #1;
        m_waitrequest = 1'b1;
        n = 0;
        for (int t = 0; t < 100 && n < 3; t++) begin
            @(negedge clk);
            if (m_chipselect) n++;
        end
        @(posedge clk);
        #1;
        m_waitrequest = 1'b0;
        wait_drain("bp");
        idle_gap(8);
        rd(4'd0, rv);
        chk("bp_done", rv, 32'h8);

        // Backpressure with run cleared during the stall.
        sw(4'd1, 32'd3);
        sw(4'd2, 32'd2);
        push_seq(2, 3, 2);
        expq[1].gap = 0;
        base = acc_cnt;
        sw(4'd0, 32'h3);
        prev_acc = last_wr_cyc;
        wait_acc("bpstop", base + 1);
        #1;
        m_waitrequest = 1'b1;
        n = 0;
        for (int t = 0; t < 100 && n < 1; t++) begin
            @(negedge clk);
            if (m_chipselect) n++;
        end
        @(posedge clk);
        #1;
        sw(4'd0, 32'h0);
        @(negedge clk);
        chk("bpstop_cs_held", 32'(m_chipselect), 32'd1);
        @(posedge clk);
        #1;
        m_waitrequest = 1'b0;
        wait_drain("bpstop");
        idle_gap(10);
        chk("bpstop_count", 32'(acc_cnt - base), 32'd2);
        rd(4'd3, rv);
        chk("bpstop_status", rv, 32'd1);

        // Clamping.
        set_pat(0, 32'hFFFF_FFFF);
        rd(4'd8, rv);
        chk("pat_mask", rv, 32'h1FF);
        run_oneshot(0, 0);
        run_oneshot(3, 0);
        for (int i = 0; i < 8; i++) set_pat(i, 32'(i * 37 + 3));
        sw(4'd2, 32'd12);
        rd(4'd2, rv);
        chk("length_readback", rv, 32'd12);
        run_oneshot(12, 1);

        // Done set by hardware in the same cycle as a clear-done write.
        sw(4'd1, 32'd3);
        sw(4'd2, 32'd2);
        push_seq(2, 3, 2);
        base = acc_cnt;
        sw(4'd0, 32'h1);
        prev_acc = last_wr_cyc;
        wait_acc("arb", base + 2);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
        end
        sw(4'd0, 32'h4);
        rd(4'd0, rv);
        chk("arb_done_wins", rv, 32'h8);
        run_oneshot(1, 2);

        // Randomized one-shot and loop runs.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) set_pat(i, $urandom);
            run_oneshot($urandom_range(0, 12), $urandom_range(0, 5));
        end
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) set_pat(i, $urandom);
            run_loop($urandom_range(0, 12), $urandom_range(2, 5), $urandom_range(1, 10));
        end

        idle_gap(10);
        if (expq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL final_queue: got %0d pending want 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ledg_sequencer.md
# ledg_sequencer

Autonomous pattern sequencer that drives the green-LED PIO without CPU involvement. The Nios loads up to DEPTH LED patterns, a step period and a sequence length through an Avalon-MM slave. When started, the block masters a series of Avalon-MM writes into the LEDG PIO data register, one pattern per step, either once or looping. It sits between the Nios data master (slave side) and the LEDG PIO s1 port (master side).

## Interface
- WIDTH, 9: LED pattern width; matches the LEDG PIO data width.
- DEPTH, 8: pattern entries; legal range 1..8.
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- s_address  in  4  slave register address
- s_chipselect  in  1  slave select
- s_write_n  in  1  slave write strobe, active-low
- s_writedata  in  32  slave write data
- s_readdata  out  32  slave read data; combinational from s_address; zero wait states
- m_address  out  2  master address to PIO; constant 0
- m_chipselect  out  1  master select
- m_write_n  out  1  master write strobe, active-low
- m_writedata  out  32  {zero-pad, pattern}
- m_waitrequest  in  1  PIO backpressure; tie 0 for the plain PIO

## Operation
- Slave write occurs when s_chipselect=1 and s_write_n=0.
- Register map:
  - 0 CTRL. Write: bit0 run, bit1 loop, bit2 clear done (self-clearing). Read: bit0 run, bit1 loop, bit3 done.
  - 1 PERIOD, 32 bit. Number of WAIT cycles per step; a stored 0 is treated as 1.
  - 2 LENGTH, 4 bit. Number of steps. 0 is treated as 1; values above DEPTH are treated as DEPTH. Readback returns the stored value.
  - 3 STATUS, read-only. bits[3:0] current index, bit4 busy (state≠IDLE).
  - 8..8+DEPTH-1 PATTERN[i]. Stores writedata[WIDTH-1:0]; reads back zero-extended.
  - Unmapped addresses read 0; writes to them are ignored.
- FSM states: IDLE, WRITE, WAIT.
  - IDLE → WRITE: run rises from 0 to 1. On this transition index←0 and done←0.
  - WRITE: drive m_chipselect=1, m_write_n=0, m_writedata={0, PATTERN[index]}. All three are held stable while m_waitrequest=1. On the acceptance cycle (m_waitrequest=0), load cnt←PERIOD_eff−1; go to WAIT, or to IDLE if run=0.
  - WAIT: cnt decrements each cycle. When cnt==0:
    - if run=0: go to IDLE;
    - else if index<LENGTH_eff−1: index+1, go to WRITE;
    - else if loop=1: index←0, go to WRITE;
    - else: done←1, run←0, go to IDLE.
- Software clearing run:
  - during WAIT: go to IDLE on the next cycle;
  - during WRITE: the pending write completes, then the FSM goes to IDLE.
  - The LEDs keep the last pattern written.
- Writing run=1 while busy: no restart; the loop bit updates.
- Writes to PERIOD, LENGTH and PATTERN are allowed at any time. Each value takes effect at its next use (cnt load, end-of-step compare, WRITE of that entry).
- Simultaneous CTRL clear-done and hardware done-set in the same cycle: set wins.

## Timing
- Reset values: every register is 0; state IDLE; m_chipselect=0, m_write_n=1, m_writedata=0, m_address=0. An asynchronous reset mid-write drops the master strobes immediately.
- Start latency: CTRL write at cycle N → m_chipselect high at N+1.
- Step spacing with m_waitrequest=0: consecutive write acceptances are PERIOD_eff+1 cycles apart.
- Backpressure: each cycle of m_waitrequest=1 in WRITE extends that step by one cycle.
- done and run=0 are visible on the cycle after the final cnt==0.
- Outside WRITE: m_chipselect=0 and m_write_n=1.

## Test plan
- Reset: assert reset_n=0 mid-WRITE → m_chipselect=0 and m_write_n=1 asynchronously. After release, all register reads return 0.
- One-shot: PATTERN0..2 = 0x001, 0x002, 0x004; LENGTH=3; PERIOD=4; CTRL=0x1 → exactly three writes of 0x001, 0x002, 0x004, acceptances 5 cycles apart. Then CTRL reads 0x8, and there are no further writes.
- Loop and stop: PATTERN0/1 = 0x1FF/0x000; LENGTH=2; PERIOD=2; CTRL=0x3 → writes alternate 0x1FF, 0x000, 0x1FF, 0x000, acceptances 3 cycles apart. Clear run during WAIT → no further writes; STATUS bit4=0.
- Backpressure: hold m_waitrequest=1 for 3 cycles on the second write → address, data and strobes stable throughout; that step is 3 cycles longer. Clear run during the stall → the write completes, then IDLE.
- Clamping: PERIOD=0 → 2-cycle spacing. LENGTH=0 → one write. LENGTH=12 with DEPTH=8 → 8 writes. Write PATTERN 0xFFFFFFFF → reads back 0x1FF and drives m_writedata=0x000001FF.
- Done arbitration: CTRL write of 0x4 in the same cycle hardware sets done → done reads 1. A new run start → done reads 0.
